// File: rtl/hwag_pkg.sv
// Shared types and default sizing for the hardware angle generator crank-sync path.
// Constants only; no latency and no backpressure apply here.
package hwag_pkg;

    localparam int HWAG_PCNT_WIDTH = 8;
    localparam int HWAG_TCNT_WIDTH = 6;
    localparam int HWAG_TOOTH_NUM  = 58;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        SYNC   = 2'd2
    } sync_state_t;

endpackage

// File: rtl/hwag_gap_cmp.sv
// Missing-tooth detector: the middle period must exceed twice each of its neighbours.
// Combinational, zero latency; no backpressure.
module hwag_gap_cmp #(
    parameter int PCNT_WIDTH = 8
) (
    input  logic [PCNT_WIDTH-1:0] pcnt1,
    input  logic [PCNT_WIDTH-1:0] pcnt2,
    input  logic [PCNT_WIDTH-1:0] pcnt3,
    input  logic                  vcnt_full,
    output logic                  gap
);

    logic [PCNT_WIDTH:0] w_p2;
    logic [PCNT_WIDTH:0] w_p1_x2;
    logic [PCNT_WIDTH:0] w_p3_x2;

    // One extra bit so doubling cannot wrap; strict compare keeps all-zero history out.
    assign w_p2    = {1'b0, pcnt2};
    assign w_p1_x2 = {pcnt1, 1'b0};
    assign w_p3_x2 = {pcnt3, 1'b0};

    assign gap = vcnt_full && (w_p2 > w_p1_x2) && (w_p2 > w_p3_x2);

endmodule

// File: rtl/hwag_sync.sv
// Crank sync FSM: finds the gap, verifies it over one revolution, then tracks the tooth index.
// Latency 2 clocks from cap_edge to outputs, 1 clock from pcnt_ovf to stall; no backpressure.
module hwag_sync
    import hwag_pkg::*;
#(
    parameter int PCNT_WIDTH = HWAG_PCNT_WIDTH,
    parameter int TCNT_WIDTH = HWAG_TCNT_WIDTH,
    parameter int TOOTH_NUM  = HWAG_TOOTH_NUM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_edge,
    input  logic                  pcnt_ovf,
    input  logic [PCNT_WIDTH-1:0] pcnt1,
    input  logic [PCNT_WIDTH-1:0] pcnt2,
    input  logic [PCNT_WIDTH-1:0] pcnt3,
    output logic [TCNT_WIDTH-1:0] tcnt,
    output logic                  sync,
    output logic                  gap_strobe,
    output logic                  sync_err,
    output logic                  stall
);

    localparam logic [TCNT_WIDTH-1:0] TCNT_LAST = TCNT_WIDTH'(TOOTH_NUM - 1);
    localparam logic [TCNT_WIDTH-1:0] TCNT_ONE  = TCNT_WIDTH'(1);

    sync_state_t             r_state;
    sync_state_t             w_state_nxt;
    logic                    r_eval;
    logic [1:0]              r_vcnt;
    logic [TCNT_WIDTH-1:0]   r_tcnt;
    logic [TCNT_WIDTH-1:0]   w_tcnt_nxt;
    logic [TCNT_WIDTH-1:0]   w_next_t;
    logic                    r_sync;
    logic                    r_gap_strobe;
    logic                    r_sync_err;
    logic                    r_stall;
    logic                    w_gap;
    logic                    w_vcnt_full;
    logic                    w_at_pos;
    logic                    w_gs_nxt;
    logic                    w_se_nxt;

    assign w_vcnt_full = (r_vcnt == 2'd3);
    assign w_next_t    = (r_tcnt == TCNT_LAST) ? '0 : r_tcnt + TCNT_ONE;
    assign w_at_pos    = (w_next_t == TCNT_ONE);

    hwag_gap_cmp #(
        .PCNT_WIDTH (PCNT_WIDTH)
    ) u_gap_cmp (
        .pcnt1     (pcnt1),
        .pcnt2     (pcnt2),
        .pcnt3     (pcnt3),
        .vcnt_full (w_vcnt_full),
        .gap       (w_gap)
    );

    // An edge coinciding with overflow is discarded: it never becomes an evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eval  <= 1'b0;
            r_vcnt  <= 2'd0;
            r_stall <= 1'b0;
        end else begin
            r_eval <= cap_edge && !pcnt_ovf;
            if (pcnt_ovf) begin
                r_vcnt <= 2'd0;
            end else if (r_eval && !w_vcnt_full) begin
                r_vcnt <= r_vcnt + 2'd1;
            end
            if (pcnt_ovf) begin
                r_stall <= 1'b1;
            end else if (cap_edge) begin
                r_stall <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tcnt_nxt  = r_tcnt;
        w_gs_nxt    = 1'b0;
        w_se_nxt    = 1'b0;
        if (pcnt_ovf) begin
            w_state_nxt = SEARCH;
            w_tcnt_nxt  = '0;
        end else if (r_eval) begin
            unique case (r_state)
                SEARCH: begin
                    if (w_gap) begin
                        w_state_nxt = VERIFY;
                        w_tcnt_nxt  = TCNT_ONE;
                        w_gs_nxt    = 1'b1;
                    end else begin
                        w_tcnt_nxt  = '0;
                    end
                end
                VERIFY: begin
                    if (w_gap) begin
                        w_state_nxt = w_at_pos ? SYNC : VERIFY;
                        w_tcnt_nxt  = TCNT_ONE;
                        w_gs_nxt    = 1'b1;
                    end else if (w_at_pos) begin
                        w_state_nxt = SEARCH;
                        w_tcnt_nxt  = '0;
                    end else begin
                        w_tcnt_nxt  = w_next_t;
                    end
                end
                SYNC: begin
                    if (w_gap == w_at_pos) begin
                        w_tcnt_nxt  = w_next_t;
                        w_gs_nxt    = w_gap;
                    end else begin
                        w_state_nxt = SEARCH;
                        w_tcnt_nxt  = '0;
                        w_se_nxt    = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = SEARCH;
                    w_tcnt_nxt  = '0;
                end
            endcase
        end
    end

    // sync decodes the next state so it lands in the same cycle as tcnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SEARCH;
            r_tcnt       <= '0;
            r_sync       <= 1'b0;
            r_gap_strobe <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_sync       <= (w_state_nxt == SYNC);
            r_gap_strobe <= w_gs_nxt;
            r_sync_err   <= w_se_nxt;
        end
    end

    assign tcnt       = r_tcnt;
    assign sync       = r_sync;
    assign gap_strobe = r_gap_strobe;
    assign sync_err   = r_sync_err;
    assign stall      = r_stall;

endmodule

// File: tb/tb_hwag_sync.sv
// Directed bench for hwag_sync on a 60-2 wheel: normal period 10, gap period 30.
module tb_hwag_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       cap_edge;
    logic       pcnt_ovf;
    logic [7:0] pcnt1;
    logic [7:0] pcnt2;
    logic [7:0] pcnt3;
    logic [5:0] tcnt;
    logic       sync;
    logic       gap_strobe;
    logic       sync_err;
    logic       stall;

    int         n_run = 0;
    int         n_fail = 0;
    int         gs_cnt = 0;
    int         se_cnt = 0;
    logic [5:0] s_tcnt;
    logic       s_gs;
    logic       s_se;
    logic       s_sync;

    always #5 clk = ~clk;

    hwag_sync #(
        .PCNT_WIDTH (8),
        .TCNT_WIDTH (6),
        .TOOTH_NUM  (58)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cap_edge   (cap_edge),
        .pcnt_ovf   (pcnt_ovf),
        .pcnt1      (pcnt1),
        .pcnt2      (pcnt2),
        .pcnt3      (pcnt3),
        .tcnt       (tcnt),
        .sync       (sync),
        .gap_strobe (gap_strobe),
        .sync_err   (sync_err),
        .stall      (stall)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One tooth: shift the period history, strobe the edge, sample two clocks later.
    task automatic push(input logic [7:0] p);
        @(posedge clk); #1;
        pcnt3 = pcnt2;
        pcnt2 = pcnt1;
        pcnt1 = p;
        cap_edge = 1'b1;
        @(posedge clk); #1;
        cap_edge = 1'b0;
        @(posedge clk); #1;
        s_tcnt = tcnt;
        s_gs   = gap_strobe;
        s_se   = sync_err;
        s_sync = sync;
        gs_cnt += int'(s_gs);
        se_cnt += int'(s_se);
        @(posedge clk); #1;
        if (s_gs) chk("gs_width", {31'd0, gap_strobe}, 32'd0);
        if (s_se) chk("se_width", {31'd0, sync_err}, 32'd0);
        repeat (6) @(posedge clk);
    endtask

    // From tcnt = 1 in VERIFY or SYNC: one full revolution ending on the gap.
    task automatic run_rev();
        se_cnt = 0;
        for (int t = 2; t <= 57; t++) begin
            push(8'd10);
            chk("rev_tcnt", {26'd0, s_tcnt}, t);
        end
        push(8'd30);
        chk("rev_wrap", {26'd0, s_tcnt}, 32'd0);
        push(8'd10);
        chk("rev_gap_tcnt", {26'd0, s_tcnt}, 32'd1);
        chk("rev_gs", {31'd0, s_gs}, 32'd1);
        chk("rev_sync", {31'd0, s_sync}, 32'd1);
        chk("rev_no_err", se_cnt, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        cap_edge = 1'b0;
        pcnt_ovf = 1'b0;
        pcnt1 = 8'd0;
        pcnt2 = 8'd0;
        pcnt3 = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tcnt", {26'd0, tcnt}, 32'd0);
        chk("rst_sync", {31'd0, sync}, 32'd0);
        chk("rst_gs", {31'd0, gap_strobe}, 32'd0);
        chk("rst_se", {31'd0, sync_err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Warm-up: gap on the 2nd period is rejected since only two valid periods exist.
        gs_cnt = 0;
        push(8'd10);
        push(8'd30);
        push(8'd10);
        chk("warm_no_gs", gs_cnt, 32'd0);
        chk("warm_tcnt", {26'd0, s_tcnt}, 32'd0);
        for (int i = 0; i < 20; i++) push(8'd10);
        chk("search_tcnt", {26'd0, s_tcnt}, 32'd0);
        push(8'd30);
        push(8'd10);
        chk("lock1_gs", {31'd0, s_gs}, 32'd1);
        chk("lock1_tcnt", {26'd0, s_tcnt}, 32'd1);
        chk("lock1_sync", {31'd0, s_sync}, 32'd0);
        run_rev();
        run_rev();

        // False gap at tooth 20 while in SYNC.
        for (int i = 0; i < 18; i++) push(8'd10);
        chk("fg_pre_tcnt", {26'd0, s_tcnt}, 32'd19);
        push(8'd30);
        chk("fg_long_tcnt", {26'd0, s_tcnt}, 32'd20);
        push(8'd10);
        chk("fg_se", {31'd0, s_se}, 32'd1);
        chk("fg_sync", {31'd0, s_sync}, 32'd0);
        chk("fg_tcnt", {26'd0, s_tcnt}, 32'd0);
        for (int i = 0; i < 30; i++) push(8'd10);
        chk("fg_search_tcnt", {26'd0, s_tcnt}, 32'd0);
        push(8'd30);
        push(8'd10);
        chk("fg_reverify_gs", {31'd0, s_gs}, 32'd1);
        chk("fg_reverify_tcnt", {26'd0, s_tcnt}, 32'd1);
        chk("fg_reverify_sync", {31'd0, s_sync}, 32'd0);
        run_rev();

        // Missing gap: a normal period where the gap is expected.
        for (int i = 0; i < 56; i++) push(8'd10);
        chk("mg_pre_tcnt", {26'd0, s_tcnt}, 32'd57);
        push(8'd10);
        chk("mg_wrap_tcnt", {26'd0, s_tcnt}, 32'd0);
        push(8'd10);
        chk("mg_se", {31'd0, s_se}, 32'd1);
        chk("mg_sync", {31'd0, s_sync}, 32'd0);
        chk("mg_tcnt", {26'd0, s_tcnt}, 32'd0);
        push(8'd30);
        push(8'd10);
        chk("mg_reverify_tcnt", {26'd0, s_tcnt}, 32'd1);
        run_rev();

        // Stall from SYNC.
        @(posedge clk); #1;
        pcnt_ovf = 1'b1;
        @(posedge clk); #1;
        pcnt_ovf = 1'b0;
        chk("stall_set", {31'd0, stall}, 32'd1);
        chk("stall_sync", {31'd0, sync}, 32'd0);
        chk("stall_tcnt", {26'd0, tcnt}, 32'd0);
        chk("stall_no_se", {31'd0, sync_err}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_hold", {31'd0, stall}, 32'd1);
        gs_cnt = 0;
        push(8'd10);
        chk("stall_clear", {31'd0, stall}, 32'd0);
        push(8'd30);
        push(8'd10);
        chk("stall_warm_no_gs", gs_cnt, 32'd0);
        chk("stall_warm_tcnt", {26'd0, s_tcnt}, 32'd0);
        push(8'd10);
        push(8'd30);
        push(8'd10);
        chk("stall_relock_gs", {31'd0, s_gs}, 32'd1);
        chk("stall_relock_tcnt", {26'd0, s_tcnt}, 32'd1);
        push(8'd10);
        push(8'd10);
        chk("verify_tcnt3", {26'd0, s_tcnt}, 32'd3);

        // Edge and overflow together: overflow wins, no evaluation follows.
        @(posedge clk); #1;
        cap_edge = 1'b1;
        pcnt_ovf = 1'b1;
        @(posedge clk); #1;
        cap_edge = 1'b0;
        pcnt_ovf = 1'b0;
        chk("sim_stall", {31'd0, stall}, 32'd1);
        chk("sim_tcnt", {26'd0, tcnt}, 32'd0);
        @(posedge clk); #1;
        chk("sim_no_gs", {31'd0, gap_strobe}, 32'd0);
        chk("sim_tcnt2", {26'd0, tcnt}, 32'd0);
        chk("sim_stall2", {31'd0, stall}, 32'd1);

        // Asynchronous reset in the middle of VERIFY.
        for (int i = 0; i < 3; i++) push(8'd10);
        push(8'd30);
        push(8'd10);
        push(8'd10);
        push(8'd10);
        chk("pre_rst_tcnt", {26'd0, tcnt}, 32'd3);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_tcnt", {26'd0, tcnt}, 32'd0);
        chk("arst_sync", {31'd0, sync}, 32'd0);
        chk("arst_gs", {31'd0, gap_strobe}, 32'd0);
        chk("arst_se", {31'd0, sync_err}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
